// File: rtl/cpu_8096_bus_arb.sv
// Two-master bus arbiter for the 8096 core: instruction fetch and data access share one
// fabric port, with at most one transaction outstanding and bounded fetch starvation.
module cpu_8096_bus_arb #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4    // legal range 1..15
) (
  input  logic                  clk,
  input  logic                  rst,
  // fetch port (read only)
  input  logic                  f_req_valid,
  output logic                  f_req_ready,
  input  logic [ADDR_W-1:0]     f_addr,
  output logic                  f_rsp_valid,
  input  logic                  f_flush,
  // data port
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  // fabric port
  output logic                  m_req_valid,
  input  logic                  m_req_ready,
  output logic [ADDR_W-1:0]     m_addr,
  output logic                  m_we,
  output logic [DATA_W/8-1:0]   m_be,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic                  m_rsp_valid,
  input  logic [DATA_W-1:0]     m_rsp_rdata,
  output logic                  busy,
  // debug visibility
  output logic [1:0]            dbg_state,
  output logic [3:0]            dbg_starve_cnt
);
  // Handshake: a request transfers on the cycle its valid and ready are both high;
  // ready never waits on anything but IDLE and the grant decision. Response pulses
  // are single-cycle and carry no backpressure.

  localparam int              BE_W       = DATA_W / 8;
  localparam logic [3:0]      STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t     state, state_nxt;
  logic       owner_f;
  logic       drop;
  logic [3:0] starve_cnt;
  logic       fetch_ok, grant_f, grant_d, rsp_fire;

  // A flushed fetch is never granted; data wins unless fetch has hit its starvation limit.
  always_comb begin
    fetch_ok = f_req_valid && !f_flush;
    grant_f  = 1'b0;
    grant_d  = 1'b0;
    if (state == IDLE && !rst) begin
      grant_f = fetch_ok && (!d_req_valid || starve_cnt == STARVE_LIM);
      grant_d = d_req_valid && !grant_f;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_f || grant_d) state_nxt = ISSUE;
      ISSUE:   if (m_req_ready)        state_nxt = WAIT;
      WAIT:    if (m_rsp_valid)        state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rsp_fire       = (state == WAIT) && m_rsp_valid;
    f_req_ready    = grant_f;
    d_req_ready    = grant_d;
    m_req_valid    = (state == ISSUE);
    busy           = (state != IDLE);
    // A flush arriving with the response itself also suppresses the pulse.
    f_rsp_valid    = rsp_fire && owner_f && !drop && !f_flush;
    d_rsp_valid    = rsp_fire && !owner_f;
    rsp_rdata      = rsp_fire ? m_rsp_rdata : '0;
    dbg_state      = state;
    dbg_starve_cnt = starve_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_f    <= 1'b0;
      drop       <= 1'b0;
      starve_cnt <= '0;
      m_addr     <= '0;
      m_we       <= 1'b0;
      m_be       <= '0;
      m_wdata    <= '0;
    end else begin
      if (grant_f || grant_d) begin
        owner_f <= grant_f;
        m_addr  <= grant_f ? f_addr : d_addr;
        m_we    <= grant_d && d_we;
        m_be    <= grant_f ? {BE_W{1'b1}} : d_be;
        m_wdata <= grant_f ? '0 : d_wdata;
      end
      if (state == IDLE) begin
        if (grant_f || !f_req_valid)
          starve_cnt <= '0;
        else if (grant_d && starve_cnt != STARVE_LIM)
          starve_cnt <= starve_cnt + 4'd1;
      end
      if (state_nxt == IDLE)
        drop <= 1'b0;
      else if (state != IDLE && owner_f && f_flush)
        drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_8096_bus_arb.sv
// Directed bench for cpu_8096_bus_arb: a behavioural fabric answers requests, the
// stimulus pushes expected responses into exp_q, and a monitor pops them on each pulse.
module tb_cpu_8096_bus_arb;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int BE_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              f_req_valid, f_req_ready, f_rsp_valid, f_flush;
  logic [ADDR_W-1:0] f_addr, d_addr, m_addr;
  logic              d_req_valid, d_req_ready, d_we, d_rsp_valid;
  logic [BE_W-1:0]   d_be, m_be;
  logic [DATA_W-1:0] d_wdata, rsp_rdata, m_wdata, m_rsp_rdata;
  logic              m_req_valid, m_req_ready, m_we, m_rsp_valid, busy;
  logic [1:0]        dbg_state;
  logic [3:0]        dbg_starve_cnt;

  cpu_8096_bus_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_addr(f_addr),
    .f_rsp_valid(f_rsp_valid), .f_flush(f_flush),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid),
    .rsp_rdata(rsp_rdata),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_addr(m_addr),
    .m_we(m_we), .m_be(m_be), .m_wdata(m_wdata),
    .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata),
    .busy(busy), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [16:0] exp_q[$];   // {is_fetch, rdata}
  logic [16:0] exp_item;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
  endtask

  // ---------------- fabric model ----------------
  int          fab_ready_wait = 0;
  int          fab_rsp_wait   = 0;
  logic [15:0] fab_rdata      = 16'h0;
  logic        fab_stray      = 1'b0;

  initial begin
    int phase, hold, rwait;
    phase = 0; hold = 0; rwait = 0;
    m_req_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      m_req_ready = 1'b0;
      m_rsp_valid = 1'b0;
      if (rst) begin
        phase = 0;
      end else begin
        if (fab_stray) begin
          m_rsp_valid = 1'b1;
          m_rsp_rdata = 16'h5A5A;
          fab_stray   = 1'b0;
        end
        if (phase == 0 && m_req_valid) begin
          hold  = fab_ready_wait;
          phase = 1;
        end
        if (phase == 1) begin
          if (hold == 0) begin
            m_req_ready = 1'b1;
            rwait       = fab_rsp_wait;
            phase       = 2;
          end else hold--;
        end else if (phase == 2) begin
          if (rwait == 0) begin
            m_rsp_valid = 1'b1;
            m_rsp_rdata = fab_rdata;
            phase       = 0;
          end else rwait--;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (f_rsp_valid || d_rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'({f_rsp_valid, d_rsp_valid, rsp_rdata}), 64'(0));
      end else begin
        exp_item = exp_q.pop_front();
        check("rsp", 64'({f_rsp_valid, d_rsp_valid, rsp_rdata}),
              64'({exp_item[16], ~exp_item[16], exp_item[15:0]}));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    f_req_valid = 1'b0; f_flush = 1'b0; f_addr = '0;
    d_req_valid = 1'b0; d_addr = '0; d_we = 1'b0; d_be = '0; d_wdata = '0;
  endtask

  task automatic wait_grant(input string name, output logic gf, output logic gd);
    logic seen;
    seen = 1'b0; gf = 1'b0; gd = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (f_req_ready || d_req_ready) begin
        seen = 1'b1; gf = f_req_ready; gd = d_req_ready;
      end
    end
    check({name, "_seen"}, 64'(seen), 64'(1));
  endtask

  task automatic wait_not_busy(input string name);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    check(name, 64'(busy), 64'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic gf, gd, found;
    int   last;
    last = 0;
    drive_idle();
    rst = 1'b1;
    f_req_valid = 1'b1; d_req_valid = 1'b1;   // requests during reset must not be granted
    @(negedge clk);
    check("reset_ctrl", 64'({f_req_ready, d_req_ready, m_req_valid, busy, f_rsp_valid,
                             d_rsp_valid, dbg_state, dbg_starve_cnt}), 64'(0));
    check("reset_fields", 64'({m_addr, m_we, m_be, m_wdata, rsp_rdata}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; drive_idle();

    // Starvation: data wins four times, then fetch on the fifth arbitration.
    fab_ready_wait = 0; fab_rsp_wait = 0;
    @(posedge clk); #1;
    f_addr = 20'h00100; d_addr = 20'h00200; d_be = 2'b11;
    f_req_valid = 1'b1; d_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_grant("starve_grant", gf, gd);
      check($sformatf("starve_winner%0d", i), 64'({gf, gd}), (i < 4) ? 64'(2'b01) : 64'(2'b10));
      check($sformatf("starve_cnt%0d", i), 64'(dbg_starve_cnt), 64'(i));
      fab_rdata = 16'(16'h1000 + i);
      exp_q.push_back({(i == 4), fab_rdata});
    end
    @(posedge clk); #1;
    f_req_valid = 1'b0; d_req_valid = 1'b0;
    wait_not_busy("starve_done");

    // Data write with a slow fabric: fields must hold for all four ISSUE cycles.
    fab_ready_wait = 3; fab_rsp_wait = 0;
    @(negedge clk); fab_rdata = 16'h0000;
    @(posedge clk); #1;
    d_addr = 20'h12345; d_we = 1'b1; d_be = 2'b10; d_wdata = 16'hBEEF; d_req_valid = 1'b1;
    wait_grant("wr_grant", gf, gd);
    check("wr_winner", 64'({gf, gd}), 64'(2'b01));
    exp_q.push_back({1'b0, 16'h0000});
    @(posedge clk); #1;
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("wr_stable%0d", i), 64'({m_req_valid, m_addr, m_we, m_be, m_wdata}),
            64'({1'b1, 20'h12345, 1'b1, 2'b10, 16'hBEEF}));
    end
    wait_not_busy("wr_done");

    // Fetch flushed while waiting: fabric completes, no f_rsp_valid.
    fab_ready_wait = 0; fab_rsp_wait = 2;
    @(negedge clk); fab_rdata = 16'hA5A5;
    @(posedge clk); #1;
    f_addr = 20'h0FFF0; f_req_valid = 1'b1;
    wait_grant("fl_grant", gf, gd);
    check("fl_winner", 64'({gf, gd}), 64'(2'b10));
    @(posedge clk); #1;
    f_req_valid = 1'b0;
    @(negedge clk);
    check("fl_issue", 64'({m_req_valid, m_addr, m_we, m_be}), 64'({1'b1, 20'h0FFF0, 1'b0, 2'b11}));
    @(posedge clk); #1;
    f_flush = 1'b1;
    @(negedge clk);
    check("fl_in_wait", 64'(dbg_state), 64'(2));
    @(posedge clk); #1;
    f_flush = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (m_rsp_valid) found = 1'b1;
    end
    check("fl_rsp_seen", 64'(found), 64'(1));
    check("fl_suppressed", 64'({f_rsp_valid, d_rsp_valid}), 64'(0));
    check("fl_rdata", 64'(rsp_rdata), 64'(16'hA5A5));
    @(negedge clk);
    check("fl_busy_drop", 64'(busy), 64'(0));

    // Fetch presented together with flush is never granted.
    @(posedge clk); #1;
    f_addr = 20'h00444; f_req_valid = 1'b1; f_flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("ff_no_grant%0d", i), 64'({f_req_ready, busy}), 64'(0));
    end
    @(posedge clk); #1;
    drive_idle();

    // Fetch alone, back-to-back with a zero-latency fabric: one grant every 3 cycles.
    fab_ready_wait = 0; fab_rsp_wait = 0;
    @(posedge clk); #1;
    f_addr = 20'h0ABC0; f_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_grant("bb_grant", gf, gd);
      check($sformatf("bb_winner%0d", i), 64'({gf, gd}), 64'(2'b10));
      check($sformatf("bb_starve%0d", i), 64'(dbg_starve_cnt), 64'(0));
      if (i > 0) check($sformatf("bb_gap%0d", i), 64'(cyc - last), 64'(3));
      last = cyc;
      fab_rdata = 16'(16'h2000 + i);
      exp_q.push_back({1'b1, fab_rdata});
    end
    @(posedge clk); #1;
    f_req_valid = 1'b0;
    wait_not_busy("bb_done");

    // Reset in WAIT abandons the transaction; a stray response afterwards is ignored.
    fab_ready_wait = 0; fab_rsp_wait = 6;
    @(negedge clk); fab_rdata = 16'h7777;
    @(posedge clk); #1;
    d_addr = 20'h00055; d_we = 1'b0; d_be = 2'b11; d_req_valid = 1'b1;
    wait_grant("rw_grant", gf, gd);
    check("rw_winner", 64'({gf, gd}), 64'(2'b01));
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rw_in_wait", 64'(dbg_state), 64'(2));
    @(posedge clk); #2;
    rst = 1'b1; f_req_valid = 1'b1; d_req_valid = 1'b1;
    #1;
    check("rw_reset_ctrl", 64'({f_req_ready, d_req_ready, m_req_valid, busy, f_rsp_valid,
                                d_rsp_valid, dbg_state, dbg_starve_cnt}), 64'(0));
    check("rw_reset_fields", 64'({m_addr, m_we, m_be, m_wdata, rsp_rdata}), 64'(0));
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0; drive_idle();
    @(negedge clk); fab_stray = 1'b1;
    @(negedge clk);
    check("rw_stray_ignored", 64'({m_rsp_valid, f_rsp_valid, d_rsp_valid, busy}), 64'(4'b1000));
    repeat (8) @(negedge clk);
    check("rw_idle_after", 64'({busy, dbg_state}), 64'(0));

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
